id_ex_stage: RTL and testbench

//  ID/EX pipeline stage directly upstream of the ALU. Registers decoded operands and controls from ID.

---
 rtl/id_ex_stage_if.sv | 72 +++++++
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every non-clock/reset signal of the ID/EX pipeline stage.
//   ID side       : stall, flush, id_valid, rs/rt/imm data, rs/rt/rd addresses,
//                   alu_src, reg_dst, alu_op, funct, pipe controls
//   Forward side  : exmem_reg_write/rd/data, memwb_reg_write/rd/data
//   EX/ALU side   : alu_data1, alu_data2, alu_ctrl, store_data, wr_addr,
//                   ex_valid, ex_* controls
//   Hazard        : hazard (combinational, back to ID stall logic)
// Modports: slave = the stage itself, master = whoever drives ID/forwarding.
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          stall;
   logic          flush;
   logic          id_valid;
   logic [DW-1:0] rs_data;
   logic [DW-1:0] rt_data;
   logic [DW-1:0] imm;
   logic [RW-1:0] rs_addr;
   logic [RW-1:0] rt_addr;
   logic [RW-1:0] rd_addr;
   logic          alu_src;
   logic          reg_dst;
   logic [1:0]    alu_op;
   logic [5:0]    funct;
   logic          reg_write;
   logic          mem_read;
   logic          mem_write;
   logic          mem_to_reg;
   logic          exmem_reg_write;
   logic [RW-1:0] exmem_rd;
   logic [DW-1:0] exmem_data;
   logic          memwb_reg_write;
   logic [RW-1:0] memwb_rd;
   logic [DW-1:0] memwb_data;
   logic [DW-1:0] alu_data1;
   logic [DW-1:0] alu_data2;
   logic [2:0]    alu_ctrl;
   logic [DW-1:0] store_data;
   logic [RW-1:0] wr_addr;
   logic          ex_valid;
   logic          ex_reg_write;
   logic          ex_mem_read;
   logic          ex_mem_write;
   logic          ex_mem_to_reg;
   logic          hazard;

   modport slave (
      input  stall, flush, id_valid, rs_data, rt_data, imm,
             rs_addr, rt_addr, rd_addr, alu_src, reg_dst, alu_op, funct,
             reg_write, mem_read, mem_write, mem_to_reg,
             exmem_reg_write, exmem_rd, exmem_data,
             memwb_reg_write, memwb_rd, memwb_data,
      output alu_data1, alu_data2, alu_ctrl, store_data, wr_addr,
             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             hazard
   );

   modport master (
      output stall, flush, id_valid, rs_data, rt_data, imm,
             rs_addr, rt_addr, rd_addr, alu_src, reg_dst, alu_op, funct,
             reg_write, mem_read, mem_write, mem_to_reg,
             exmem_reg_write, exmem_rd, exmem_data,
             memwb_reg_write, memwb_rd, memwb_data,
      input  alu_data1, alu_data2, alu_ctrl, store_data, wr_addr,
             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             hazard
   );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the ALU. Decodes alu_op/funct into the 3-bit
// ALU control before the register, forwards EX/MEM and MEM/WB results onto the
// operands, and flags load-use hazards back to ID.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - id_ex_stage_if.slave (ID inputs, forwarding inputs, ALU outputs)
// Configuration macro: ID_EX_FWD_EN
//   defined   : operands forwarded from EX/MEM (priority) then MEM/WB
//   undefined : operands are the registered register-file data; forwarding
//               inputs are ignored. hazard is the same in both builds.
// Register update semantics (one edge, in priority order):
//   flush -> bubble (valid, controls, data all 0); else stall -> hold every
//   register; else capture the ID inputs. No other handshake exists.
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input logic          clk_i,
   input logic          rst_i,
   id_ex_stage_if.slave bus
);

   function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [5:0] fn);
      logic [2:0] code;
      code = 3'b000;
      case (op)
         2'b00: code = 3'b000;
         2'b01: code = 3'b001;
         2'b11: code = 3'b100;
         default: begin
            case (fn)
               6'b100000: code = 3'b000;
               6'b100010: code = 3'b001;
               6'b011000: code = 3'b010;
               6'b100100: code = 3'b011;
               6'b100101: code = 3'b100;
               default:   code = 3'b000;
            endcase
         end
      endcase
      return code;
   endfunction

   logic          valid_q;
   logic          reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
   logic          alu_src_q;
   logic [2:0]    alu_ctrl_q;
   logic [RW-1:0] wr_addr_q;
   logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
   logic [DW-1:0] fwd_rs, fwd_rt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_ctrl_q   <= 3'b000;
         wr_addr_q    <= '0;
         rs_data_q    <= '0;
         rt_data_q    <= '0;
         imm_q        <= '0;
      end else if (bus.flush) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_ctrl_q   <= 3'b000;
         wr_addr_q    <= '0;
         rs_data_q    <= '0;
         rt_data_q    <= '0;
         imm_q        <= '0;
      end else if (!bus.stall) begin
         valid_q      <= bus.id_valid;
         reg_write_q  <= bus.reg_write;
         mem_read_q   <= bus.mem_read;
         mem_write_q  <= bus.mem_write;
         mem_to_reg_q <= bus.mem_to_reg;
         alu_src_q    <= bus.alu_src;
         alu_ctrl_q   <= alu_decode(bus.alu_op, bus.funct);
         wr_addr_q    <= bus.reg_dst ? bus.rd_addr : bus.rt_addr;
         rs_data_q    <= bus.rs_data;
         rt_data_q    <= bus.rt_data;
         imm_q        <= bus.imm;
      end
   end

`ifdef ID_EX_FWD_EN
   // Source addresses are only needed to match against forwarding destinations.
   logic [RW-1:0] rs_addr_q, rt_addr_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rs_addr_q <= '0;
         rt_addr_q <= '0;
      end else if (bus.flush) begin
         rs_addr_q <= '0;
         rt_addr_q <= '0;
      end else if (!bus.stall) begin
         rs_addr_q <= bus.rs_addr;
         rt_addr_q <= bus.rt_addr;
      end
   end

   // EX/MEM is younger than MEM/WB, so it wins when both match. $0 never forwards.
   always_comb begin
      fwd_rs = rs_data_q;
      if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rs_addr_q))
         fwd_rs = bus.exmem_data;
      else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rs_addr_q))
         fwd_rs = bus.memwb_data;
   end

   always_comb begin
      fwd_rt = rt_data_q;
      if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rt_addr_q))
         fwd_rt = bus.exmem_data;
      else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rt_addr_q))
         fwd_rt = bus.memwb_data;
   end
`else
   assign fwd_rs = rs_data_q;
   assign fwd_rt = rt_data_q;
`endif

   assign bus.alu_data1     = fwd_rs;
   assign bus.alu_data2     = alu_src_q ? imm_q : fwd_rt;
   assign bus.store_data    = fwd_rt;
   assign bus.alu_ctrl      = alu_ctrl_q;
   assign bus.wr_addr       = wr_addr_q;
   assign bus.ex_valid      = valid_q;
   assign bus.ex_reg_write  = reg_write_q;
   assign bus.ex_mem_read   = mem_read_q;
   assign bus.ex_mem_write  = mem_write_q;
   assign bus.ex_mem_to_reg = mem_to_reg_q;

   // A load in EX whose destination is read by the instruction in ID cannot be
   // forwarded in time; $0 and bubbles never qualify.
   assign bus.hazard = valid_q && mem_read_q && (wr_addr_q != '0) &&
                       ((wr_addr_q == bus.rs_addr) || (wr_addr_q == bus.rt_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage: reset, ALU decode, operand muxing,
// forwarding priority, $0 handling, load-use hazard, stall, flush and
// asynchronous reset mid-stall. Expected forwarding values follow the
// ID_EX_FWD_EN build setting.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   logic clk_i;
   logic rst_i;
   int   checks;
   int   errors;

   id_ex_stage_if #(.DW(32), .RW(5)) bus ();

   id_ex_stage #(.DW(32), .RW(5)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   // clock
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

`ifdef ID_EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
      bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0;
      bus.rs_addr = '0; bus.rt_addr = '0; bus.rd_addr = '0;
      bus.alu_src = 0; bus.reg_dst = 0; bus.alu_op = 2'b00; bus.funct = 6'b0;
      bus.reg_write = 0; bus.mem_read = 0; bus.mem_write = 0; bus.mem_to_reg = 0;
      bus.exmem_reg_write = 0; bus.exmem_rd = '0; bus.exmem_data = '0;
      bus.memwb_reg_write = 0; bus.memwb_rd = '0; bus.memwb_data = '0;
   endtask

   logic [1:0] op_tab   [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
   logic [5:0] fn_tab   [9] = '{6'b100010, 6'b100000, 6'b000000, 6'b100000, 6'b100010,
                                6'b011000, 6'b100100, 6'b100101, 6'b111111};
   logic [2:0] ctrl_tab [9] = '{3'b000, 3'b001, 3'b100, 3'b000, 3'b001,
                                3'b010, 3'b011, 3'b100, 3'b000};

   initial begin
      checks = 0;
      errors = 0;
      idle_inputs();

      // reset state
      rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_valid", {31'b0, bus.ex_valid}, 32'd0);
      check("rst_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);
      check("rst_wr_addr", {27'b0, bus.wr_addr}, 32'd0);
      check("rst_data1", bus.alu_data1, 32'd0);
      check("rst_data2", bus.alu_data2, 32'd0);
      check("rst_store", bus.store_data, 32'd0);
      check("rst_reg_write", {31'b0, bus.ex_reg_write}, 32'd0);
      check("rst_hazard", {31'b0, bus.hazard}, 32'd0);
      rst_i = 1'b1;

      // R-type mul, plain register operands
      bus.id_valid = 1; bus.alu_op = 2'b10; bus.funct = 6'b011000;
      bus.rs_addr = 5'd1; bus.rt_addr = 5'd2; bus.rd_addr = 5'd9; bus.reg_dst = 1;
      bus.rs_data = 32'd7; bus.rt_data = 32'd6; bus.reg_write = 1;
      tick();
      check("mul_ctrl", {29'b0, bus.alu_ctrl}, 32'd2);
      check("mul_data1", bus.alu_data1, 32'd7);
      check("mul_data2", bus.alu_data2, 32'd6);
      check("mul_store", bus.store_data, 32'd6);
      check("mul_wr_addr", {27'b0, bus.wr_addr}, 32'd9);
      check("mul_valid", {31'b0, bus.ex_valid}, 32'd1);
      check("mul_reg_write", {31'b0, bus.ex_reg_write}, 32'd1);

      // ALU control decode table
      for (int i = 0; i < 9; i++) begin
         bus.alu_op = op_tab[i];
         bus.funct  = fn_tab[i];
         tick();
         check($sformatf("decode_%0d", i), {29'b0, bus.alu_ctrl}, {29'b0, ctrl_tab[i]});
      end

      // immediate operand, rt destination
      bus.alu_src = 1; bus.imm = 32'h0000_1234; bus.reg_dst = 0;
      bus.mem_write = 1; bus.mem_to_reg = 1;
      tick();
      check("imm_data2", bus.alu_data2, 32'h0000_1234);
      check("imm_store", bus.store_data, 32'd6);
      check("imm_wr_addr", {27'b0, bus.wr_addr}, 32'd2);
      check("imm_mem_write", {31'b0, bus.ex_mem_write}, 32'd1);
      check("imm_mem_to_reg", {31'b0, bus.ex_mem_to_reg}, 32'd1);

      // forwarding priority
      bus.alu_src = 0; bus.mem_write = 0; bus.mem_to_reg = 0;
      bus.rs_addr = 5'd3; bus.rs_data = 32'h11; bus.rt_addr = 5'd4; bus.rt_data = 32'h44;
      tick();
      bus.exmem_reg_write = 1; bus.exmem_rd = 5'd3; bus.exmem_data = 32'h55;
      bus.memwb_reg_write = 1; bus.memwb_rd = 5'd3; bus.memwb_data = 32'h99;
      #1;
      check("fwd_both_rs", bus.alu_data1, FWD ? 32'h55 : 32'h11);
      check("fwd_both_rt", bus.alu_data2, 32'h44);
      bus.exmem_rd = 5'd4;
      #1;
      check("fwd_memwb_rs", bus.alu_data1, FWD ? 32'h99 : 32'h11);
      check("fwd_exmem_rt", bus.alu_data2, FWD ? 32'h55 : 32'h44);
      check("fwd_exmem_store", bus.store_data, FWD ? 32'h55 : 32'h44);
      bus.exmem_reg_write = 0; bus.memwb_reg_write = 0;
      #1;
      check("fwd_off_rs", bus.alu_data1, 32'h11);

      // $0 never forwards
      bus.rs_addr = 5'd0; bus.rs_data = 32'h22;
      tick();
      bus.exmem_reg_write = 1; bus.exmem_rd = 5'd0; bus.exmem_data = 32'hFF;
      bus.memwb_reg_write = 1; bus.memwb_rd = 5'd0; bus.memwb_data = 32'hEE;
      #1;
      check("zero_no_fwd", bus.alu_data1, 32'h22);
      bus.exmem_reg_write = 0; bus.memwb_reg_write = 0;

      // load-use hazard: lw $4 in EX
      bus.mem_read = 1; bus.reg_write = 1; bus.mem_to_reg = 1; bus.reg_dst = 0;
      bus.rs_addr = 5'd1; bus.rt_addr = 5'd4; bus.rs_data = 32'h31;
      tick();
      check("hz_rt_match", {31'b0, bus.hazard}, 32'd1);
      bus.rs_addr = 5'd4; bus.rt_addr = 5'd7;
      #1;
      check("hz_rs_match", {31'b0, bus.hazard}, 32'd1);
      bus.rs_addr = 5'd5; bus.rt_addr = 5'd6;
      #1;
      check("hz_no_match", {31'b0, bus.hazard}, 32'd0);
      bus.rt_addr = 5'd4;

      // stall holds the load in EX
      bus.stall = 1; bus.rs_data = 32'hAAAA; bus.mem_read = 0; bus.alu_op = 2'b01;
      tick();
      check("stall_mem_read", {31'b0, bus.ex_mem_read}, 32'd1);
      check("stall_wr_addr", {27'b0, bus.wr_addr}, 32'd4);
      check("stall_data1", bus.alu_data1, 32'h31);
      check("stall_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);
      check("stall_hazard", {31'b0, bus.hazard}, 32'd1);

      // flush beats stall
      bus.flush = 1;
      tick();
      check("flush_valid", {31'b0, bus.ex_valid}, 32'd0);
      check("flush_reg_write", {31'b0, bus.ex_reg_write}, 32'd0);
      check("flush_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);
      check("flush_mem_read", {31'b0, bus.ex_mem_read}, 32'd0);
      check("flush_data1", bus.alu_data1, 32'd0);
      check("flush_hazard", {31'b0, bus.hazard}, 32'd0);

      // load $0 never raises hazard
      bus.flush = 0; bus.stall = 0; bus.mem_read = 1; bus.rt_addr = 5'd0; bus.rs_addr = 5'd0;
      tick();
      check("hz_zero_dest", {31'b0, bus.hazard}, 32'd0);

      // asynchronous reset while stalled
      bus.mem_read = 0; bus.reg_dst = 1; bus.rd_addr = 5'd12; bus.rs_data = 32'h77;
      tick();
      check("pre_rst_valid", {31'b0, bus.ex_valid}, 32'd1);
      bus.stall = 1;
      #2;
      rst_i = 1'b0;
      #1;
      check("async_rst_valid", {31'b0, bus.ex_valid}, 32'd0);
      check("async_rst_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);
      check("async_rst_wr_addr", {27'b0, bus.wr_addr}, 32'd0);
      check("async_rst_data1", bus.alu_data1, 32'd0);
      tick();
      rst_i = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
